// File: rtl/alu_operand_stage.sv
// alu_operand_stage: pipeline register in front of the ALU.
// It accepts one decoded op per cycle over valid/ready and selects the
// immediate or the register operand. RAW hazards are resolved by forwarding
// either the ALU result of the retiring op or the last retired write. The
// stage also keeps a saturating stall counter for performance debug.
module alu_operand_stage #(
  parameter int unsigned CNT_W  = 16,
  parameter bit          FWD_EN = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [4:0]       rs1_addr_i,
  input  logic [4:0]       rs2_addr_i,
  input  logic [31:0]      rs1_data_i,
  input  logic [31:0]      rs2_data_i,
  input  logic [31:0]      imm_i,
  input  logic             use_imm_i,
  input  logic [3:0]       ALUctrl_in_i,
  input  logic [4:0]       rd_addr_i,
  input  logic             rd_we_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      srcA_o,
  output logic [31:0]      srcB_o,
  output logic [3:0]       ALUctrl_o,
  output logic [4:0]       rd_addr_o,
  output logic             rd_we_o,
  input  logic [31:0]      alu_result_i,
  output logic [CNT_W-1:0] stall_cnt_o
);

  logic        fire_in;
  logic        fire_out;
  logic        retire_wr;
  logic        stall;

  // Last retired register write. buf_rd is never x0 because x0 writes are not captured.
  logic        buf_valid;
  logic [4:0]  buf_rd;
  logic [31:0] buf_data;

  logic [31:0] fwd_a;
  logic [31:0] fwd_b;

  assign fire_out   = out_valid_o & out_ready_i;
  assign in_ready_o = ~flush_i & (~out_valid_o | out_ready_i);
  assign fire_in    = in_valid_i & in_ready_o;
  // A flushed op never retires, so it must neither forward nor update the buffer.
  assign retire_wr  = fire_out & ~flush_i & rd_we_o & (rd_addr_o != 5'd0);
  assign stall      = out_valid_o & ~out_ready_i & ~flush_i;

  // Pick the source operand values. The retiring op has priority over the buffer, and x0 is never forwarded.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    fwd_a = rs1_data_i;
    fwd_b = rs2_data_i;
    if (FWD_EN) begin
      if (rs1_addr_i != 5'd0) begin
        if (retire_wr && (rd_addr_o == rs1_addr_i))
          fwd_a = alu_result_i;
        else if (buf_valid && (buf_rd == rs1_addr_i))
          fwd_a = buf_data;
      end
      if (rs2_addr_i != 5'd0) begin
        if (retire_wr && (rd_addr_o == rs2_addr_i))
          fwd_b = alu_result_i;
        else if (buf_valid && (buf_rd == rs2_addr_i))
          fwd_b = buf_data;
      end
    end
  end

  // Held-op register: a flush drops the op, a new op loads, a consumed op empties the stage, otherwise it holds.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, independent of block ordering.
    if (!rst_n_i) begin
      out_valid_o <= 1'b0;
      srcA_o      <= '0;
      srcB_o      <= '0;
      ALUctrl_o   <= '0;
      rd_addr_o   <= '0;
      rd_we_o     <= 1'b0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
    end else if (fire_in) begin
      out_valid_o <= 1'b1;
      srcA_o      <= fwd_a;
      srcB_o      <= use_imm_i ? imm_i : fwd_b;
      ALUctrl_o   <= ALUctrl_in_i;
      rd_addr_o   <= rd_addr_i;
      rd_we_o     <= rd_we_i;
    end else if (fire_out) begin
      out_valid_o <= 1'b0;
    end
  end

  // Last-retired buffer: captures each retiring non-x0 write and is cleared only by reset.
  always_ff @(posedge clk_i) begin
    // NOTE: only buf_valid needs a reset for correctness, but the data is reset too so the outputs never show X after reset.
    if (!rst_n_i) begin
      buf_valid <= 1'b0;
      buf_rd    <= '0;
      buf_data  <= '0;
    end else if (retire_wr) begin
      buf_valid <= 1'b1;
      buf_rd    <= rd_addr_o;
      buf_data  <= alu_result_i;
    end
  end

  // Stall counter: counts cycles where the held op is blocked downstream, and saturates at all-ones.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i)
      stall_cnt_o <= '0;
    else if (stall && (stall_cnt_o != {CNT_W{1'b1}}))
      stall_cnt_o <= stall_cnt_o + CNT_W'(1);
  end

endmodule
